// File: rtl/chad_pkg.sv
// Shared chad constants: cell/address widths and the RAM-owner encoding used by
// the data-memory arbiter.
package chad_pkg;
  localparam int CELL_W = 18;
  localparam int ADDR_W = 15;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;
endpackage

// File: rtl/chad_mem_arbiter.sv
// Shares chad's single-port data RAM with a secondary master. The CPU has priority;
// a one-cycle forced hold bounds how long a secondary request can wait.
module chad_mem_arbiter
  import chad_pkg::*;
#(
  parameter int WIDTH   = CELL_W,
  parameter int AWIDTH  = ADDR_W,
  parameter int MAXWAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [WIDTH-1:0]  cpu_wdata,
  output logic [WIDTH-1:0]  cpu_rdata,
  output logic              cpu_hold,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [AWIDTH-1:0] dma_addr,
  input  logic [WIDTH-1:0]  dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [WIDTH-1:0]  dma_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_wdata,
  input  logic [WIDTH-1:0]  ram_q
);
  localparam int CW = $clog2(MAXWAIT + 1);

  owner_e            owner;
  logic [CW-1:0]     starve_cnt;
  logic              hold_nxt;
  logic              cpu_rd_go;
  logic              cpu_rd_d1;
  logic              dma_rd_d1;
  logic [WIDTH-1:0]  cpu_cap;

  // A forced cycle belongs to the secondary master even if it dropped its request;
  // no access of either side is started while reset is asserted.
  always_comb begin
    owner = OWN_NONE;
    if (reset)               owner = OWN_NONE;
    else if (cpu_hold)       owner = dma_req ? OWN_DMA : OWN_NONE;
    else if (cpu_rd || cpu_wr) owner = OWN_CPU;
    else if (dma_req)        owner = OWN_DMA;
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (owner)
      OWN_CPU: begin
        ram_en    = 1'b1;
        ram_we    = cpu_wr;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
      OWN_DMA: begin
        ram_en    = 1'b1;
        ram_we    = dma_we;
        ram_addr  = dma_addr;
        ram_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

  assign dma_gnt   = (owner == OWN_DMA);
  // rd+wr together is a write, so no read data is captured for it
  assign cpu_rd_go = (owner == OWN_CPU) && cpu_rd && !cpu_wr;
  assign hold_nxt  = dma_req && !dma_gnt && !cpu_hold &&
                     (starve_cnt == CW'(MAXWAIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_hold   <= 1'b0;
      starve_cnt <= '0;
      cpu_rd_d1  <= 1'b0;
      dma_rd_d1  <= 1'b0;
      cpu_cap    <= '0;
    end else begin
      cpu_hold  <= hold_nxt;
      cpu_rd_d1 <= cpu_rd_go;
      dma_rd_d1 <= dma_gnt && !dma_we;
      if (cpu_rd_d1) cpu_cap <= ram_q;
      if (dma_gnt || !dma_req)            starve_cnt <= '0;
      else if (starve_cnt != CW'(MAXWAIT)) starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // mem_din must stay put across hold cycles, hence the captured copy
  assign cpu_rdata  = cpu_rd_d1 ? ram_q : cpu_cap;
  assign dma_rvalid = dma_rd_d1;
  assign dma_rdata  = ram_q;
endmodule
